// File: rtl/bch_chien.sv
// BCH Chien search over GF(2^M), one data bit per clock.
//
// A word's error-locator polynomial sigma is loaded from bch_key when start
// is high and the block is idle. Each term sigma_j * x^j is held in its own
// register, pre-scaled so the first evaluated point is alpha^(N-DATA_BITS+1).
// Every RUN cycle each term is stepped by alpha^j, which advances the
// evaluation point by one. A bit is flagged when the terms XOR to zero.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             sigma/err_count valid
//   sigma[M*(T+1)]    coefficients, sigma[j*M+:M] = sigma_j
//   err_count         error count reported by bch_key
//   accepted          start consumed this cycle (combinational)
//   busy              search in progress, start ignored
//   err/err_valid     per-bit error flag and its strobe
//   err_first/last    strobes for data bit 0 / DATA_BITS-1
//   mismatch          flagged count != err_count, only with err_last

// One sigma term: load with a fixed pre-scale, then multiply by a fixed
// power of alpha each step. Both multipliers reduce to XOR networks.
module bch_chien_term #(
  parameter int         M         = 4,
  parameter logic [M:0] POLY      = 5'h13,
  parameter int         LOAD_EXP  = 0,
  parameter int         STEP_EXP  = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [M-1:0] sigma_j,
  output logic [M-1:0] r
);
  localparam int N = (1 << M) - 1;

  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY[M-1:0] : '0);
  endfunction

  // Exponent is an elaboration constant, so the loop unrolls into wiring.
  function automatic logic [M-1:0] mul_apow(input logic [M-1:0] x, input int e);
    logic [M-1:0] y;
    y = x;
    for (int i = 0; i < N; i++)
      if (i < e) y = mul_alpha(y);
    return y;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r <= '0;
    else if (load) r <= mul_apow(sigma_j, LOAD_EXP);
    else if (step) r <= mul_apow(r, STEP_EXP);
  end
endmodule

module bch_chien #(
  parameter int M         = 4,
  parameter int T         = 3,
  parameter int DATA_BITS = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [M*(T+1)-1:0]     sigma,
  input  logic [$clog2(T+1)-1:0] err_count,
  output logic                   accepted,
  output logic                   busy,
  output logic                   err,
  output logic                   err_valid,
  output logic                   err_first,
  output logic                   err_last,
  output logic                   mismatch
);
  localparam int N   = (1 << M) - 1;
  localparam int ECW = $clog2(T+1);
  localparam int KW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DATA_BITS - 1);

  // Primitive polynomials; M=4 gives x^4+x+1.
  function automatic logic [16:0] prim_poly(input int m);
    case (m)
      2: return 17'h7;      3: return 17'hB;      4: return 17'h13;
      5: return 17'h25;     6: return 17'h43;     7: return 17'h89;
      8: return 17'h11D;    9: return 17'h211;    10: return 17'h409;
      11: return 17'h805;   12: return 17'h1053;  13: return 17'h201B;
      14: return 17'h4443;  15: return 17'h8003;  default: return 17'h1002D;
    endcase
  endfunction
  localparam logic [16:0] PP   = prim_poly(M);
  localparam logic [M:0]  POLY = PP[M:0];

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [T:0][M-1:0] r;
  logic [M-1:0]      sum;
  logic [KW-1:0]     k;
  logic [ECW:0]      found, found_nx;
  logic [ECW-1:0]    ecnt;
  logic              eval, hit;

  assign accepted = start && (state == IDLE) && !reset;
  assign busy     = (state == RUN);

  for (genvar j = 0; j <= T; j++) begin : g_term
    bch_chien_term #(
      .M(M), .POLY(POLY),
      .LOAD_EXP((j * (N - DATA_BITS + 1)) % N),
      .STEP_EXP(j % N)
    ) u_term (
      .clk(clk), .reset(reset), .load(accepted), .step(eval),
      .sigma_j(sigma[j*M +: M]), .r(r[j])
    );
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j <= T; j++) sum ^= r[j];
  end

  assign hit      = eval && (sum == '0);
  assign found_nx = (hit && found != '1) ? found + 1'b1 : found;

  // RUN spans the evaluation cycles plus the cycle presenting the last
  // flag, so busy covers err_last and the next start lands one cycle later.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accepted) state_nx = RUN;
      RUN:     if (err_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k         <= '0;
      found     <= '0;
      ecnt      <= '0;
      eval      <= 1'b0;
      err       <= 1'b0;
      err_valid <= 1'b0;
      err_first <= 1'b0;
      err_last  <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      err_valid <= eval;
      err       <= hit;
      err_first <= eval && (k == '0);
      err_last  <= eval && (k == K_LAST);
      mismatch  <= eval && (k == K_LAST) && (found_nx != {1'b0, ecnt});
      if (accepted) begin
        ecnt  <= err_count;
        found <= '0;
        k     <= '0;
        eval  <= 1'b1;
      end else if (eval) begin
        found <= found_nx;
        if (k == K_LAST) eval <= 1'b0;
        else             k    <= k + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bch_chien.sv
module tb_bch_chien;
  localparam int M = 4, T = 3, D = 5, N = 15;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] sigma;
  logic [1:0]  err_count;
  logic        accepted, busy, err, err_valid, err_first, err_last, mismatch;

  bch_chien #(.M(M), .T(T), .DATA_BITS(D)) dut (
    .clk(clk), .reset(reset), .start(start), .sigma(sigma),
    .err_count(err_count), .accepted(accepted), .busy(busy), .err(err),
    .err_valid(err_valid), .err_first(err_first), .err_last(err_last),
    .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0, fails = 0;
  int idle_at = 0, acc_c = -100;

  typedef struct {
    int   cyc;
    logic err, first, last, mm;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference GF(16) arithmetic, x^4+x+1, shift-and-add multiply.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, aa;
    p = '0; aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] alpha_pow(input int e);
    logic [3:0] x;
    x = 4'h1;
    for (int i = 0; i < e; i++) x = gf_mul(x, 4'h2);
    return x;
  endfunction

  // Direct Horner-free evaluation of sigma at alpha^(11+k).
  task automatic push_word(input logic [15:0] sg, input logic [1:0] ec, input int c0);
    int   found;
    exp_t e;
    logic [3:0] x, xp, v;
    found = 0;
    for (int k = 0; k < D; k++) begin
      x = alpha_pow((N - D + 1 + k) % N);
      v = '0; xp = 4'h1;
      for (int j = 0; j <= T; j++) begin
        v ^= gf_mul(sg[j*4 +: 4], xp);
        xp = gf_mul(xp, x);
      end
      if (v == 0 && found < 7) found++;
      e.cyc   = c0 + 2 + k;
      e.err   = (v == 0);
      e.first = (k == 0);
      e.last  = (k == D - 1);
      e.mm    = (k == D - 1) && (found != int'(ec));
      q.push_back(e);
    end
  endtask

  task automatic step(input logic s, input logic [15:0] sg, input logic [1:0] ec);
    logic ea;
    @(negedge clk);
    start = s; sigma = sg; err_count = ec;
    #1;
    ea = s && !reset && (cyc >= idle_at);
    chk("accepted", accepted, ea);
    chk("busy", busy, !reset && cyc > acc_c && cyc < idle_at);
    if (ea) begin
      push_word(sg, ec, cyc);
      acc_c   = cyc;
      idle_at = cyc + 2 + D;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 2'd0);
  endtask

  // Scoreboard: compare each err_valid cycle with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset) begin
      if (err_valid) begin
        if (q.size() == 0) chk("unexpected_err_valid", err_valid, 0);
        else begin
          e = q.pop_front();
          chk("err_cycle", cyc, e.cyc);
          chk("err", err, e.err);
          chk("err_first", err_first, e.first);
          chk("err_last", err_last, e.last);
          chk("mismatch", mismatch, e.mm);
        end
      end else begin
        chk("quiet_flags", {err, err_first, err_last, mismatch}, 0);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; sigma = '0; err_count = '0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    #1;
    chk("reset_outputs", {accepted, busy, err, err_valid, err_first, err_last, mismatch}, 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;

    // zero errors
    step(1'b1, 16'h0001, 2'd0); idle(8);
    // single error at alpha^13 (k=2)
    step(1'b1, 16'h0041, 2'd1); idle(8);
    // count disagreement
    step(1'b1, 16'h0041, 2'd2); idle(8);
    // start held high: accepts every 7 cycles, busy in between
    repeat (16) step(1'b1, 16'h0041, 2'd1);
    idle(8);
    // all-zero sigma: every bit flags
    step(1'b1, 16'h0000, 2'd3); idle(8);
    // random words
    repeat (4) begin
      step(1'b1, 16'($urandom), 2'($urandom_range(0, 3)));
      idle(8);
    end

    // reset in cycle 4 of a search
    step(1'b1, 16'h0041, 2'd1);
    idle(3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {accepted, busy, err, err_valid, err_first, err_last, mismatch}, 0);
    q.delete();
    idle_at = 0; acc_c = -100;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 16'h0041, 2'd1);
    idle(10);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/bch_chien.md
BCH_CHIEN -- requirements
Module: bch_chien

Interface
REQ-001 Parameter M, default 4: GF(2^M) symbol width; field is the codebase's shared bch.vh field. N = 2^M-1.
REQ-002 Parameter T, default 3: correction capability; sigma has T+1 coefficients.
REQ-003 Parameter DATA_BITS, default 5: data bits searched, 1 <= DATA_BITS <= N.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 start  in  1  sigma/err_count valid (driven by bch_key done).
REQ-008 sigma  in  M*(T+1)  coefficients; sigma[j*M+:M] = sigma_j, j=0..T.
REQ-009 err_count  in  log2(T+1)  error count from bch_key.
REQ-010 accepted  out  1  start consumed this cycle (drives bch_key accepted).
REQ-011 busy  out  1  search in progress; start is ignored.
REQ-012 err  out  1  error flag for the current data bit.
REQ-013 err_valid  out  1  err is valid.
REQ-014 err_first  out  1  err_valid cycle for data bit 0.
REQ-015 err_last  out  1  err_valid cycle for data bit DATA_BITS-1.
REQ-016 mismatch  out  1  flagged count != err_count; valid only with err_last.

Function
REQ-017 States: IDLE, RUN. Reset state IDLE.
REQ-018 accepted = start && state==IDLE, combinational; start while busy is not accepted and is not latched.
REQ-019 On the accepted edge, load register r_j = sigma_j * alpha^(j*(N-DATA_BITS+1)) (exponent mod N) for each j; latch err_count; clear found counter; go to RUN.
REQ-020 In RUN, each cycle: r_j <= r_j * alpha^j; k increments from 0 to DATA_BITS-1.
REQ-021 Bit k flags when sum over j of r_j == 0, i.e. sigma(alpha^(N-DATA_BITS+1+k)) == 0.
REQ-022 err, err_valid, err_first and err_last are registered. With start accepted in cycle c, the flags for bit k appear in cycle c+2+k.
REQ-023 Exactly DATA_BITS consecutive err_valid cycles per accepted start. There is no output backpressure.
REQ-024 Found counter: width log2(T+1)+1 bits, saturating, increments on each flagged bit.
REQ-025 mismatch in the err_last cycle = (found count including that bit != latched err_count); mismatch is 0 in all other cycles.
REQ-026 busy is 1 from cycle c+1 through the err_last cycle inclusive. State returns to IDLE after err_last, so a start in cycle c+2+DATA_BITS is accepted.
REQ-027 DATA_BITS=1: err_first and err_last are asserted in the same cycle.
REQ-028 sigma all zero: every bit flags. This is not special-cased; mismatch follows REQ-025.
REQ-029 GF multiplies by the constants alpha^j are combinational XOR networks. The adder tree is combinational within one cycle.

Reset
REQ-030 Reset asserted at any time, including mid-RUN:
- state goes to IDLE immediately;
- accepted, busy, err, err_valid, err_first, err_last, mismatch go to 0;
- r_j, k and the counter are cleared.
REQ-031 After reset deasserts, the first start is accepted per REQ-018. No partial output of the interrupted word is resumed.

Verification
(All scenarios use M=4, T=3, DATA_BITS=5, field x^4+x+1, so the evaluation point is alpha^(11+k).)
REQ-032 Zero errors: sigma={1,0,0,0}, err_count=0, start in cycle 0 -> accepted in cycle 0; err_valid in cycles 2..6; err=0 throughout; err_last in cycle 6 with mismatch=0.
REQ-033 Single error: sigma0=1, sigma1=alpha^2 (4'b0100), others 0, err_count=1 -> err=1 only at k=2 (cycle 4); mismatch=0.
REQ-034 Count disagreement: the REQ-033 sigma with err_count=2 -> err at k=2 only; mismatch=1 in the err_last cycle.
REQ-035 Busy handshake: start held high continuously from cycle 0 -> accepted only in cycles 0 and 7; busy in cycles 1..6; two complete 5-bit bursts, with the second err_first in cycle 9.
REQ-036 Mid-operation reset: reset asserted in cycle 4 of a search -> all outputs 0 in that cycle; no err_last ever appears for that word; a new start in the cycle after reset deasserts is accepted with normal timing.
